tsc_ctrl: RTL

- Sampling controller that drives the ADC req/rdy/dat handshake.
- Captures 8-bit samples into a 32-entry ring buffer and detects a threshold trigger.
- After the trigger, acquires POST_CNT further samples, then streams the whole buffer MSB-first on a serial output.
- Sits between the ADC model and the downstream serial sink/host.

---
 rtl/tsc_pkg.sv | 42 ++++
 rtl/tsc_ser.sv | 92 +++++++++
 rtl/tsc_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/tsc_pkg.sv
// -----------------------------------------------------------------------------
// tsc_pkg
// Shared constants, widths and state encoding for the tsc_ctrl sampling
// controller and its serialiser.
//
// Build option:
//   TSC_PARITY_EN - when defined, every serial byte is followed by one
//                   even-parity bit (9-bit frames); otherwise 8-bit frames.
// -----------------------------------------------------------------------------
package tsc_pkg;

    localparam int DEPTH      = 32;   // ring-buffer entries, power of 2
    localparam int POST_CNT   = 16;   // samples kept after the trigger sample
    localparam int SAMPLE_DIV = 8;    // min cycles between req rising edges
    localparam int TIMEOUT    = 15;   // max cycles to wait for rdy
    localparam int HOLD_MIN   = 2;    // min cycles in WAIT before rdy is trusted

    localparam int PTR_W = $clog2(DEPTH);

`ifdef TSC_PARITY_EN
    localparam int FRAME_BITS = 9;
`else
    localparam int FRAME_BITS = 8;
`endif

    localparam int BIT_W  = $clog2(FRAME_BITS);
    localparam int HOLD_W = $clog2(TIMEOUT);
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int POST_W = $clog2(POST_CNT + 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARST  = 3'd1,
        REQ   = 3'd2,
        WAIT  = 3'd3,
        STORE = 3'd4,
        GAP   = 3'd5,
        XMIT  = 3'd6,
        DONE  = 3'd7
    } tsc_state_e;

endpackage

// File: rtl/tsc_ser.sv
// -----------------------------------------------------------------------------
// tsc_ser
// Parallel-to-serial shifter for the buffer dump. Sends DEPTH bytes MSB first,
// one bit per clock, asking for each byte by index through byte_idx_o.
//
// Build option: TSC_PARITY_EN appends an even-parity bit after each byte.
//
// Ports:
//   clk_i       system clock
//   rst_i       synchronous active-high reset
//   load_i      start a new frame on the next cycle
//   flush_i     drop any frame in progress
//   byte_i      byte currently addressed by byte_idx_o
//   byte_idx_o  index (0..DEPTH-1) of the byte being shifted
//   sd_o        serial data
//   sd_vld_o    serial data qualifier
//   done_o      high during the final bit of the frame
// -----------------------------------------------------------------------------
module tsc_ser
    import tsc_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             flush_i,
    input  logic [7:0]       byte_i,
    output logic [PTR_W-1:0] byte_idx_o,
    output logic             sd_o,
    output logic             sd_vld_o,
    output logic             done_o
);

    logic             active_q, active_d;
    logic [BIT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [PTR_W-1:0] byte_idx_q, byte_idx_d;
    logic             last_bit, last_byte, sd_bit;

    assign last_bit  = (bit_cnt_q == '0);
    assign last_byte = (byte_idx_q == PTR_W'(DEPTH - 1));

`ifdef TSC_PARITY_EN
    // bit_cnt 8..1 carry data bits 7..0, bit_cnt 0 carries the parity bit
    logic [2:0] bit_sel;
    assign bit_sel = 3'(bit_cnt_q - BIT_W'(1));
    assign sd_bit  = last_bit ? (^byte_i) : byte_i[bit_sel];
`else
    assign sd_bit  = byte_i[bit_cnt_q];
`endif

    always_comb begin
        active_d   = active_q;
        bit_cnt_d  = bit_cnt_q;
        byte_idx_d = byte_idx_q;
        if (flush_i) begin
            active_d   = 1'b0;
            bit_cnt_d  = '0;
            byte_idx_d = '0;
        end else if (load_i) begin
            active_d   = 1'b1;
            bit_cnt_d  = BIT_W'(FRAME_BITS - 1);
            byte_idx_d = '0;
        end else if (active_q) begin
            if (last_bit) begin
                bit_cnt_d  = BIT_W'(FRAME_BITS - 1);
                byte_idx_d = byte_idx_q + PTR_W'(1);
                if (last_byte) begin
                    active_d = 1'b0;
                end
            end else begin
                bit_cnt_d = bit_cnt_q - BIT_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            active_q   <= 1'b0;
            bit_cnt_q  <= '0;
            byte_idx_q <= '0;
        end else begin
            active_q   <= active_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    assign byte_idx_o = byte_idx_q;
    assign sd_o       = active_q & sd_bit;
    assign sd_vld_o   = active_q;
    assign done_o     = active_q & last_bit & last_byte;

endmodule

// File: rtl/tsc_ctrl.sv
// -----------------------------------------------------------------------------
// tsc_ctrl
// ADC sampling controller: paces req/rdy/dat conversions into a DEPTH-entry
// ring buffer, arms on the first sample strictly above trig_lvl_i, keeps
// POST_CNT more samples, then dumps the whole buffer oldest-first on sd_o.
//
// Build option: TSC_PARITY_EN (see tsc_ser) selects 9-bit serial frames.
//
// state | meaning
// IDLE  | waiting for start_i
// ARST  | one-cycle ADC reset pulse
// REQ   | raise req, clear hold counter, restart sample pacing
// WAIT  | req held, wait for rdy after HOLD_MIN cycles or time out
// STORE | write sample, evaluate trigger / post-trigger count
// GAP   | req low until SAMPLE_DIV cycles since last REQ
// XMIT  | serial dump of the buffer
// DONE  | one quiet cycle before IDLE
//
// Ports:
//   clk_i, rst_i   clock, synchronous active-high reset
//   start_i        begin acquisition (IDLE only)
//   abort_i        return to IDLE from any state
//   trig_lvl_i     trigger threshold
//   adc_rst_o      ADC reset pulse
//   req_o, rdy_i, dat_i   ADC handshake
//   busy_o, trd_o, err_o  status
//   sd_o, sd_vld_o        serial dump
// -----------------------------------------------------------------------------
module tsc_ctrl
    import tsc_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_i,
    input  logic       abort_i,
    input  logic [7:0] trig_lvl_i,
    output logic       adc_rst_o,
    output logic       req_o,
    input  logic       rdy_i,
    input  logic [7:0] dat_i,
    output logic       busy_o,
    output logic       trd_o,
    output logic       err_o,
    output logic       sd_o,
    output logic       sd_vld_o
);

    tsc_state_e        state_q, state_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [POST_W-1:0] post_q, post_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [7:0]        smp_q, smp_d;
    logic              trd_q, trd_d;
    logic              err_q, err_d;
    logic [7:0]        mem_q [DEPTH];
    logic              mem_we, mem_clr, ser_load, ser_done;
    logic [PTR_W-1:0]  byte_idx, rd_addr;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            hold_q   <= '0;
            div_q    <= '0;
            post_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            smp_q    <= '0;
            trd_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            hold_q   <= hold_d;
            div_q    <= div_d;
            post_q   <= post_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            smp_q    <= smp_d;
            trd_q    <= trd_d;
            err_q    <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || mem_clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else if (mem_we) begin
            mem_q[wr_ptr_q] <= smp_q;
        end
    end

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        // pacing counter free-runs down to zero once loaded in REQ
        div_d    = (div_q != '0) ? div_q - DIV_W'(1) : div_q;
        post_d   = post_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        smp_d    = smp_q;
        trd_d    = trd_q;
        err_d    = err_q;
        mem_we   = 1'b0;
        mem_clr  = 1'b0;
        ser_load = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start_i) begin
                        mem_clr  = 1'b1;
                        wr_ptr_d = '0;
                        trd_d    = 1'b0;
                        err_d    = 1'b0;
                        state_d  = ARST;
                    end
                end
                ARST: state_d = REQ;
                REQ: begin
                    hold_d  = '0;
                    div_d   = DIV_W'(SAMPLE_DIV - 1);
                    state_d = WAIT;
                end
                WAIT: begin
                    // rdy may still be high from the previous conversion
                    if (rdy_i && (hold_q >= HOLD_W'(HOLD_MIN))) begin
                        smp_d   = dat_i;
                        state_d = STORE;
                    end else if (hold_q == HOLD_W'(TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
                STORE: begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    state_d  = GAP;
                    if (!trd_q) begin
                        if (smp_q > trig_lvl_i) begin
                            trd_d  = 1'b1;
                            post_d = POST_W'(POST_CNT);
                        end
                    end else begin
                        post_d = post_q - POST_W'(1);
                        if (post_q == POST_W'(1)) begin
                            // slot after the newest sample holds the oldest one
                            rd_ptr_d = wr_ptr_q + PTR_W'(1);
                            ser_load = 1'b1;
                            state_d  = XMIT;
                        end
                    end
                end
                GAP: begin
                    if (div_q <= DIV_W'(1)) begin
                        state_d = REQ;
                    end
                end
                XMIT: begin
                    if (ser_done) begin
                        state_d = DONE;
                    end
                end
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        busy_o    = (state_q != IDLE);
        adc_rst_o = (state_q == ARST);
        req_o     = (state_q == REQ) || (state_q == WAIT) || (state_q == STORE);
        trd_o     = trd_q;
        err_o     = err_q;
    end

    assign rd_addr = rd_ptr_q + byte_idx;

    tsc_ser u_ser (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load_i     (ser_load),
        .flush_i    (abort_i),
        .byte_i     (mem_q[rd_addr]),
        .byte_idx_o (byte_idx),
        .sd_o       (sd_o),
        .sd_vld_o   (sd_vld_o),
        .done_o     (ser_done)
    );

endmodule
